// File: rtl/m_unit_pkg.sv
// Shared types and constants for the RV32M multiply/divide unit.
package m_unit_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_DONE
  } state_t;

  localparam logic [2:0] F3_MUL    = 3'd0;
  localparam logic [2:0] F3_MULH   = 3'd1;
  localparam logic [2:0] F3_MULHSU = 3'd2;
  localparam logic [2:0] F3_MULHU  = 3'd3;
  localparam logic [2:0] F3_DIV    = 3'd4;
  localparam logic [2:0] F3_DIVU   = 3'd5;
  localparam logic [2:0] F3_REM    = 3'd6;
  localparam logic [2:0] F3_REMU   = 3'd7;

  localparam int DIV_ITER = 32;
  localparam logic [DATA_W-1:0] DIV_BY_ZERO_Q = 32'hFFFF_FFFF;

endpackage

// File: rtl/m_unit_radix2_divider.sv
// Unsigned radix-2 restoring divider: one quotient bit per cycle after start.
module radix2_divider
  import m_unit_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic              done,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder
);

  logic [4:0]        cnt_p1;
  logic              active_p1;
  logic [DATA_W-1:0] rem_p1;
  logic [DATA_W-1:0] quo_p1;
  logic [DATA_W-1:0] dvsr_p1;
  logic [DATA_W:0]   trial;
  logic [DATA_W:0]   diff;

  // Bit DATA_W of diff is the borrow: set when the shifted remainder is below the divisor.
  always_comb begin
    trial = {rem_p1, quo_p1[DATA_W-1]};
    diff  = trial - {1'b0, dvsr_p1};
  end

  // Iteration stage: dividend bits shift out of quo_p1 as quotient bits shift in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_p1    <= '0;
      active_p1 <= 1'b0;
      done      <= 1'b0;
      rem_p1    <= '0;
      quo_p1    <= '0;
      dvsr_p1   <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        cnt_p1    <= '0;
        active_p1 <= 1'b1;
        rem_p1    <= '0;
        quo_p1    <= dividend;
        dvsr_p1   <= divisor;
      end else if (active_p1) begin
        quo_p1 <= {quo_p1[DATA_W-2:0], ~diff[DATA_W]};
        rem_p1 <= diff[DATA_W] ? trial[DATA_W-1:0] : diff[DATA_W-1:0];
        cnt_p1 <= cnt_p1 + 5'd1;
        if (cnt_p1 == 5'(DIV_ITER - 1)) begin
          active_p1 <= 1'b0;
          done      <= 1'b1;
        end
      end
    end
  end

  assign quotient  = quo_p1;
  assign remainder = rem_p1;

endmodule

// File: rtl/m_unit.sv
// RV32M execute-stage multiply/divide unit: 2-cycle multiply, 34-cycle iterative divide.
module m_unit
  import m_unit_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m_start,
  input  logic              pipeline_flush,
  input  logic [2:0]        func3,
  input  logic [DATA_W-1:0] op1,
  input  logic [DATA_W-1:0] op2,
  input  logic [4:0]        rd,
  input  logic              wb_en,
  output logic              m_unit_busy,
  output logic              m_unit_ready,
  output logic [DATA_W-1:0] m_unit_result,
  output logic              m_unit_wr,
  output logic [4:0]        m_unit_dest
);

  function automatic logic [DATA_W-1:0] cond_neg(input logic [DATA_W-1:0] v, input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  state_t            state, state_nx;
  logic              accept;
  logic              sdiv_in, dz_in, ovf_in, div_start;
  logic [2:0]        f3_p1;
  logic [DATA_W-1:0] op1_p1, op2_p1, res_p1;
  logic [4:0]        rd_p1;
  logic              wb_p1, dz_p1, ovf_p1, sdiv_p1;
  logic              div_done;
  logic [DATA_W-1:0] div_quo, div_rem;
  logic signed [DATA_W:0]     a33, b33;
  logic signed [2*DATA_W-1:0] prod;
  logic [DATA_W-1:0] mul_res, div_q, div_r, div_res;

  assign accept    = (state == ST_IDLE) && m_start && !pipeline_flush;
  assign sdiv_in   = !func3[0];
  assign dz_in     = (op2 == '0);
  assign ovf_in    = sdiv_in && (op1 == 32'h8000_0000) && (op2 == 32'hFFFF_FFFF);
  assign div_start = accept && func3[2] && !dz_in && !ovf_in;

  radix2_divider u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (div_start),
    .dividend  (cond_neg(op1, sdiv_in && op1[DATA_W-1])),
    .divisor   (cond_neg(op2, sdiv_in && op2[DATA_W-1])),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  // Only MULHU zero-extends op1; only MULH sign-extends op2 (MUL keeps low bits either way).
  always_comb begin
    a33     = {(f3_p1 != F3_MULHU) && op1_p1[DATA_W-1], op1_p1};
    b33     = {(f3_p1 == F3_MULH) && op2_p1[DATA_W-1], op2_p1};
    prod    = 64'(a33) * 64'(b33);
    mul_res = (f3_p1 == F3_MUL) ? prod[DATA_W-1:0] : prod[2*DATA_W-1:DATA_W];
  end

  always_comb begin
    div_q = cond_neg(div_quo, sdiv_p1 && (op1_p1[DATA_W-1] ^ op2_p1[DATA_W-1]));
    div_r = cond_neg(div_rem, sdiv_p1 && op1_p1[DATA_W-1]);
    if (dz_p1)
      div_res = f3_p1[1] ? op1_p1 : DIV_BY_ZERO_Q;
    else if (ovf_p1)
      div_res = f3_p1[1] ? '0 : 32'h8000_0000;
    else
      div_res = f3_p1[1] ? div_r : div_q;
  end

  always_comb begin
    state_nx    = state;
    m_unit_busy = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          m_unit_busy = 1'b1;
          state_nx    = func3[2] ? ST_DIV : ST_MUL;
        end
      end
      ST_MUL: begin
        m_unit_busy = 1'b1;
        state_nx    = ST_DONE;
      end
      ST_DIV: begin
        m_unit_busy = 1'b1;
        if (dz_p1 || ovf_p1 || div_done) state_nx = ST_DONE;
      end
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  // Accept stage latches the instruction; result stage captures the final value once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f3_p1   <= '0;
      op1_p1  <= '0;
      op2_p1  <= '0;
      rd_p1   <= '0;
      wb_p1   <= 1'b0;
      dz_p1   <= 1'b0;
      ovf_p1  <= 1'b0;
      sdiv_p1 <= 1'b0;
      res_p1  <= '0;
    end else begin
      if (accept) begin
        f3_p1   <= func3;
        op1_p1  <= op1;
        op2_p1  <= op2;
        rd_p1   <= rd;
        wb_p1   <= wb_en;
        dz_p1   <= dz_in;
        ovf_p1  <= ovf_in;
        sdiv_p1 <= sdiv_in;
      end
      if (state == ST_MUL)
        res_p1 <= mul_res;
      else if ((state == ST_DIV) && (state_nx == ST_DONE))
        res_p1 <= div_res;
    end
  end

  assign m_unit_ready  = (state == ST_DONE);
  assign m_unit_result = m_unit_ready ? res_p1 : '0;
  assign m_unit_dest   = m_unit_ready ? rd_p1 : '0;
  assign m_unit_wr     = m_unit_ready && wb_p1 && (rd_p1 != 5'd0);

endmodule

// File: doc/m_unit.md
M_UNIT -- requirements
Module: m_unit

Interface
REQ-001 clk  input  1  rising-edge clock for all state.
REQ-002 rst_n  input  1  asynchronous, active-low reset.
REQ-003 m_start  input  1  a valid RV32M instruction is in the execute stage (opcode OP, func7=0000001).
REQ-004 pipeline_flush  input  1  the execute-stage instruction is being squashed.
REQ-005 func3  input  3  operation: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-006 op1, op2  input  32 each  forwarded rs1 and rs2 values from the execute stage.
REQ-007 rd  input  5  destination register.
REQ-008 wb_en  input  1  the instruction writes the register file.
REQ-009 m_unit_busy  output  1  stall request to the hazard unit.
REQ-010 m_unit_ready  output  1  single-cycle result strobe to the execute stage.
REQ-011 m_unit_result  output  32  result; 0 when m_unit_ready=0.
REQ-012 m_unit_wr  output  1  write enable; valid only when m_unit_ready=1.
REQ-013 m_unit_dest  output  5  destination register; 0 when m_unit_ready=0.

Function
REQ-014 States: IDLE, MUL, DIV, DONE; all outputs are registered from the state and datapath registers.
REQ-015 Accept occurs at a rising edge when state=IDLE, m_start=1 and pipeline_flush=0; the edge latches func3, op1, op2, rd and wb_en.
REQ-016 m_start is ignored in every state other than IDLE, and m_start with pipeline_flush=1 is never accepted.
REQ-017 Transitions: IDLE->MUL for func3[2]=0; IDLE->DIV for func3[2]=1; MUL->DONE after 1 cycle; DIV->DONE after 32 iterations; DONE->IDLE unconditionally.
REQ-018 A multiply produces m_unit_ready in the 2nd cycle after the accept edge (latency 2).
REQ-019 The multiply forms a 64-bit product from 33-bit sign- or zero-extended operands: MULH signed x signed, MULHSU signed x unsigned, MULHU unsigned x unsigned; MUL returns bits[31:0], and the three high variants return bits[63:32].
REQ-020 A divide performs a radix-2 restoring division on operand magnitudes, one quotient bit per cycle, so m_unit_ready falls in the 34th cycle after the accept edge.
REQ-021 For a signed divide, the quotient sign is op1[31]^op2[31] and the remainder sign follows op1.
REQ-022 Divide by zero bypasses the iterations (DIV->DONE next cycle, latency 2): quotient = 0xFFFFFFFF and remainder = op1.
REQ-023 Signed overflow (op1=0x80000000, op2=0xFFFFFFFF, DIV/REM only) also bypasses the iterations with latency 2: quotient = 0x80000000, remainder = 0.
REQ-024 m_unit_busy = 1 in MUL and DIV, and is combinationally 1 in IDLE when an accept is occurring.
REQ-025 m_unit_busy = 0 in DONE, so the pipeline advances in the same cycle it consumes the result.
REQ-026 m_unit_ready = 1 only in DONE, for exactly one cycle, together with m_unit_result, m_unit_dest = latched rd and m_unit_wr = latched wb_en & (rd!=0).
REQ-027 pipeline_flush after the accept is ignored; the accepted instruction always completes, because the stall prevents any younger redirect.
REQ-028 Back-to-back: a new m_start in the cycle after DONE is accepted normally, with no bubble beyond DONE->IDLE.

Reset
REQ-029 rst_n=0 immediately forces state=IDLE and m_unit_busy, m_unit_ready, m_unit_wr = 0, and clears m_unit_result, m_unit_dest and all datapath registers.
REQ-030 A reset asserted mid-operation discards the operation, and no m_unit_ready follows the release of reset.

Structure
REQ-031 Shared package m_unit_pkg holds the state enum, the func3 encodings (F3_MUL..F3_REMU) and the constants DIV_ITER=32 and DIV_BY_ZERO_Q=32'hFFFFFFFF.
REQ-032 A single sub-module, radix2_divider, holds the iteration counter, remainder and quotient registers and the start/done handshake; m_unit instantiates it once.
REQ-033 The multiplier is inline: one 33x33 signed product registered once.

Verification
REQ-034 MULH: op1=0xFFFFFFFF, op2=0xFFFFFFFF, rd=5 -> ready at cycle 2 with result=0x00000000, dest=5, wr=1; MULHU with the same operands -> 0xFFFFFFFE.
REQ-035 DIV: op1=-7 (0xFFFFFFF9), op2=2 -> busy for 33 cycles, ready at cycle 34 with result=0xFFFFFFFD; REM with the same operands -> 0xFFFFFFFF.
REQ-036 DIVU: op1=100, op2=0 -> ready at cycle 2 with 0xFFFFFFFF; REMU with the same operands -> 100.
REQ-037 DIV: op1=0x80000000, op2=0xFFFFFFFF -> ready at cycle 2 with 0x80000000; REM with the same operands -> 0.
REQ-038 m_start with pipeline_flush=1 -> no accept, busy=0 and no ready; m_start while in DIV -> ignored, and only one ready occurs.
REQ-039 rst_n driven low at cycle 10 of a DIV -> outputs 0 immediately, and no ready in the 40 cycles after release; MUL with rd=0 -> ready=1, wr=0.
